// File: rtl/data_sram_responder_pkg.sv
// Shared like-SRAM bus definitions and the response-entry layout used by the data-side responder.
package data_sram_responder_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
    localparam int STRB_W = BUS_DW / 8;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Per-entry latency countdown; bounds LATENCY to 2**CNT_W.
    localparam int CNT_W = 8;

    typedef struct packed {
        logic              is_wr;
        logic [1:0]        size;
        logic [BUS_DW-1:0] rdata;
        logic [CNT_W-1:0]  cnt;
    } resp_entry_t;

    localparam int RESP_ENTRY_W = $bits(resp_entry_t);

endpackage

// File: rtl/data_sram_responder_resp_fifo.sv
// In-order response queue: each entry counts its own latency down and the head is
// flagged ready once its countdown has expired.
module resp_fifo
    import data_sram_responder_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  resp_entry_t   push_entry,
    input  logic          pop,
    output resp_entry_t   head,
    output logic          head_ready,
    output logic [CW-1:0] count
);

    resp_entry_t     entries [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries[i].cnt != '0) entries[i].cnt <= entries[i].cnt - 1'b1;
            end
            // The pushed slot is never the one being popped, so the later write wins cleanly.
            if (push) begin
                entries[wr_ptr] <= push_entry;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head       = entries[rd_ptr];
    assign head_ready = (count != '0) && (head.cnt == '0);

endmodule

// File: rtl/data_sram_responder.sv
// Data-side like-SRAM responder: word RAM with byte strobes, answering every accepted
// request once, in order, after a fixed minimum latency.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int AW      = 10,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_sram_req,
    input  logic              data_sram_wr,
    input  logic [1:0]        data_sram_size,
    input  logic [BUS_AW-1:0] data_sram_addr,
    input  logic [STRB_W-1:0] data_sram_wstrb,
    input  logic [BUS_DW-1:0] data_sram_wdata,
    output logic              data_sram_addr_ok,
    output logic              data_sram_data_ok,
    output logic [BUS_DW-1:0] data_sram_rdata,
    input  logic              resp_stall
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [BUS_DW-1:0] ram [2**AW];
    logic [AW-1:0]     word_idx;
    logic [CW-1:0]     count;
    logic              accept;
    logic              head_ready;
    resp_entry_t       head;
    resp_entry_t       push_entry;
    logic              unused_bits;

    assign word_idx = data_sram_addr[AW+1:2];

    // Acceptance looks only at the registered count: a full queue never admits a
    // request even if the head is popping this same cycle.
    assign data_sram_addr_ok = ~reset & (count < DEPTH_C);
    assign accept            = data_sram_req & data_sram_addr_ok;
    assign data_sram_data_ok = head_ready & ~resp_stall;
    assign data_sram_rdata   = (data_sram_data_ok & ~head.is_wr) ? head.rdata : '0;

    always_comb begin
        push_entry       = '0;
        push_entry.is_wr = data_sram_wr;
        push_entry.size  = data_sram_size;
        push_entry.rdata = data_sram_wr ? '0 : ram[word_idx];
        push_entry.cnt   = CNT_W'(LATENCY - 1);
    end

    // Loads sample the RAM combinationally above, so they see the pre-store contents.
    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (data_sram_wstrb[b]) ram[word_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
            end
        end
    end

    resp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_entry (push_entry),
        .pop        (data_sram_data_ok),
        .head       (head),
        .head_ready (head_ready),
        .count      (count)
    );

    assign unused_bits = ^{data_sram_addr[BUS_AW-1:AW+2], data_sram_addr[1:0], head.size};

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomised and directed checks of the data-side responder against a queue-based model.
module tb_data_sram_responder;

    localparam int AW = 10, DEPTH = 4, LAT = 2;

    logic clk = 1'b0, reset = 1'b0;
    always #5 clk = ~clk;

    logic req = 0, wr = 0, stall = 0;
    logic [1:0] size = 2'd2;
    logic [31:0] addr = 0, wdata = 0;
    logic [3:0] wstrb = 0;
    logic addr_ok, data_ok;
    logic [31:0] rdata;

    logic r1_req = 0, r1_wr = 0;
    logic [31:0] r1_addr = 0, r1_wdata = 0;
    logic [3:0] r1_wstrb = 0;
    logic a1_ok, d1_ok;
    logic [31:0] rd1;

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    data_sram_responder #(.AW(AW), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
        .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(wstrb),
        .data_sram_wdata(wdata), .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok),
        .data_sram_rdata(rdata), .resp_stall(stall)
    );

    data_sram_responder #(.AW(AW), .DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .data_sram_req(r1_req), .data_sram_wr(r1_wr),
        .data_sram_size(2'd2), .data_sram_addr(r1_addr), .data_sram_wstrb(r1_wstrb),
        .data_sram_wdata(r1_wdata), .data_sram_addr_ok(a1_ok), .data_sram_data_ok(d1_ok),
        .data_sram_rdata(rd1), .resp_stall(1'b0)
    );

    // Reference: outstanding responses with the earliest cycle they may appear, plus a RAM image.
    typedef struct { logic [31:0] data; int ready; } exp_t;
    typedef struct { logic [31:0] d; int c; } obs_t;
    exp_t q[$];
    obs_t rlog[$];
    logic [31:0] mmem [0:(1<<AW)-1];

    initial begin : scoreboard
        exp_t e;
        obs_t o;
        logic ea, ed;
        logic [AW-1:0] wi;
        forever begin
            @(negedge clk);
            if (reset) begin
                ea = 0; ed = 0; q.delete();
            end else begin
                ea = (q.size() < DEPTH);
                ed = (q.size() > 0) && (cyc >= q[0].ready) && !stall;
            end
            total++;
            if (addr_ok !== ea) begin bad++; $display("FAIL sb_addr_ok cyc=%0d got=%b exp=%b", cyc, addr_ok, ea); end
            total++;
            if (data_ok !== ed) begin bad++; $display("FAIL sb_data_ok cyc=%0d got=%b exp=%b", cyc, data_ok, ed); end
            total++;
            if (ed) begin
                if (rdata !== q[0].data) begin bad++; $display("FAIL sb_rdata cyc=%0d got=%h exp=%h", cyc, rdata, q[0].data); end
                void'(q.pop_front());
            end else if (rdata !== 32'h0) begin
                bad++; $display("FAIL sb_rdata_idle cyc=%0d got=%h exp=0", cyc, rdata);
            end
            if (data_ok) begin o.d = rdata; o.c = cyc; rlog.push_back(o); end
            if (!reset && req && ea) begin
                wi = addr[AW+1:2];
                e.data = wr ? 32'h0 : mmem[wi];
                e.ready = cyc + LAT;
                q.push_back(e);
                if (wr) for (int b = 0; b < 4; b++) if (wstrb[b]) mmem[wi][8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output int acc);
        req = 1; wr = w; addr = a; wstrb = s; wdata = d; size = 2'd2;
        acc = -1;
        for (int k = 0; k < 200 && acc < 0; k++) begin
            @(negedge clk);
            if (addr_ok) acc = cyc;
            tick();
        end
        req = 0;
        total++;
        if (acc < 0) begin bad++; $display("FAIL issue_timeout got=none exp=accept addr=%h", a); end
    endtask

    task automatic wait_log(input int n);
        for (int k = 0; k < 300 && rlog.size() < n; k++) tick();
        total++;
        if (rlog.size() < n) begin bad++; $display("FAIL resp_timeout got=%0d exp=%0d", rlog.size(), n); end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300 && q.size() != 0; k++) tick();
        tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({addr_ok, data_ok, rdata} !== 34'h0) begin
                bad++; $display("FAIL reset_outputs got=%b/%b/%h exp=0/0/0", addr_ok, data_ok, rdata);
            end
        end
        tick();
        reset = 0;
        @(negedge clk);
        total++;
        if (addr_ok !== 1'b1) begin bad++; $display("FAIL post_reset_addr_ok got=%b exp=1", addr_ok); end
        tick();
    endtask

    task automatic prefill();
        int acc;
        for (int i = 0; i < 17; i++) issue(1, 32'(i * 4), 4'hF, $urandom, acc);
        wait_idle();
    endtask

    task automatic test_store_load();
        int a0, a1, base;
        base = rlog.size();
        issue(1, 32'h10, 4'hF, 32'hDEADBEEF, a0);
        issue(0, 32'h10, 4'hF, 32'h0, a1);
        wait_log(base + 2);
        total++;
        if (rlog[base+1].d !== 32'hDEADBEEF) begin bad++; $display("FAIL store_load_data got=%h exp=deadbeef", rlog[base+1].d); end
        total++;
        if (rlog[base+1].c - a1 !== LAT) begin bad++; $display("FAIL store_load_latency got=%0d exp=%0d", rlog[base+1].c - a1, LAT); end
        wait_idle();
    endtask

    task automatic test_strobe();
        int a, base;
        base = rlog.size();
        issue(1, 32'h20, 4'hF, 32'h11223344, a);
        issue(1, 32'h20, 4'b0100, 32'h00AA0000, a);
        issue(0, 32'h22, 4'h0, 32'h0, a);
        wait_log(base + 3);
        total++;
        if (rlog[base+2].d !== 32'h11AA3344) begin bad++; $display("FAIL strobe_merge got=%h exp=11aa3344", rlog[base+2].d); end
        wait_idle();
    endtask

    task automatic test_load_before_store();
        int a, base;
        issue(1, 32'h30, 4'hF, 32'h1, a);
        wait_idle();
        base = rlog.size();
        issue(0, 32'h30, 4'h0, 32'h0, a);
        issue(1, 32'h30, 4'hF, 32'h2, a);
        issue(0, 32'h30, 4'h0, 32'h0, a);
        wait_log(base + 3);
        total++;
        if (rlog[base].d !== 32'h1) begin bad++; $display("FAIL inflight_load got=%h exp=1", rlog[base].d); end
        total++;
        if (rlog[base+2].d !== 32'h2) begin bad++; $display("FAIL later_load got=%h exp=2", rlog[base+2].d); end
        wait_idle();
    endtask

    task automatic test_full_stall();
        int a, base;
        logic [31:0] exp_v [5];
        for (int j = 0; j < 5; j++) exp_v[j] = mmem[j + (j == 4 ? 1 : 0)];
        base = rlog.size();
        stall = 1;
        for (int j = 0; j < 4; j++) issue(0, 32'(j * 4), 4'h0, 32'h0, a);
        req = 1; wr = 0; addr = 32'h14;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (addr_ok !== 1'b0) begin bad++; $display("FAIL full_addr_ok got=%b exp=0", addr_ok); end
            tick();
        end
        stall = 0;
        @(negedge clk);
        total++;
        if ({data_ok, addr_ok} !== 2'b10) begin bad++; $display("FAIL full_pop_cycle got=%b%b exp=10", data_ok, addr_ok); end
        tick();
        @(negedge clk);
        total++;
        if (addr_ok !== 1'b1) begin bad++; $display("FAIL full_reaccept got=%b exp=1", addr_ok); end
        tick();
        req = 0;
        wait_log(base + 5);
        for (int j = 0; j < 5; j++) begin
            total++;
            if (rlog[base+j].d !== exp_v[j]) begin bad++; $display("FAIL full_order[%0d] got=%h exp=%h", j, rlog[base+j].d, exp_v[j]); end
        end
        wait_idle();
    endtask

    task automatic test_lat1_stream();
        logic [31:0] v [8];
        logic [31:0] ev;
        for (int i = 0; i < 16; i++) begin
            r1_req = 1;
            if (i < 8) begin
                v[i] = $urandom; r1_wr = 1; r1_addr = 32'h200 + 32'(4 * i); r1_wdata = v[i]; r1_wstrb = 4'hF;
            end else begin
                r1_wr = 0; r1_addr = 32'h200 + 32'(4 * (i - 8)); r1_wstrb = 4'h0;
            end
            @(negedge clk);
            total++;
            if (a1_ok !== 1'b1) begin bad++; $display("FAIL lat1_addr_ok[%0d] got=%b exp=1", i, a1_ok); end
            total++;
            if (d1_ok !== (i > 0)) begin bad++; $display("FAIL lat1_data_ok[%0d] got=%b exp=%b", i, d1_ok, i > 0); end
            if (i > 0) begin
                ev = (i - 1 < 8) ? 32'h0 : v[i-9];
                total++;
                if (rd1 !== ev) begin bad++; $display("FAIL lat1_rdata[%0d] got=%h exp=%h", i, rd1, ev); end
            end
            tick();
        end
        r1_req = 0;
        @(negedge clk);
        total++;
        if ({d1_ok, rd1} !== {1'b1, v[7]}) begin bad++; $display("FAIL lat1_last got=%b/%h exp=1/%h", d1_ok, rd1, v[7]); end
        tick();
        @(negedge clk);
        total++;
        if (d1_ok !== 1'b0) begin bad++; $display("FAIL lat1_drain got=%b exp=0", d1_ok); end
        tick();
    endtask

    task automatic test_reset_mid();
        int a, base;
        issue(1, 32'h40, 4'hF, 32'h55, a);
        wait_idle();
        base = rlog.size();
        stall = 1;
        for (int j = 0; j < 3; j++) issue(0, 32'(j * 4), 4'h0, 32'h0, a);
        reset = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if ({addr_ok, data_ok} !== 2'b00) begin bad++; $display("FAIL midreset_outputs got=%b%b exp=00", addr_ok, data_ok); end
            tick();
        end
        reset = 0; stall = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if (data_ok !== 1'b0) begin bad++; $display("FAIL midreset_stale_resp got=%b exp=0", data_ok); end
            tick();
        end
        total++;
        if (rlog.size() !== base) begin bad++; $display("FAIL midreset_resp_count got=%0d exp=%0d", rlog.size(), base); end
        issue(0, 32'h40, 4'h0, 32'h0, a);
        wait_log(base + 1);
        total++;
        if (rlog[base].d !== 32'h55) begin bad++; $display("FAIL midreset_store_kept got=%h exp=55", rlog[base].d); end
        wait_idle();
    endtask

    task automatic test_random();
        int n_acc = 0, base;
        logic held = 0;
        base = rlog.size();
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom % 4 == 0);
            if (!held) begin
                req   = ($urandom % 3 != 0);
                wr    = $urandom % 2;
                size  = 2'($urandom % 3);
                addr  = ($urandom & 32'hFFFF_F000) | 32'(($urandom % 16) << 2) | 32'($urandom % 4);
                wstrb = 4'($urandom);
                wdata = $urandom;
            end
            @(negedge clk);
            held = req && !addr_ok;
            if (req && addr_ok) n_acc++;
            tick();
        end
        req = 0; stall = 0;
        wait_idle();
        total++;
        if (rlog.size() - base !== n_acc) begin bad++; $display("FAIL random_resp_count got=%0d exp=%0d", rlog.size() - base, n_acc); end
    endtask

    initial begin
        #1 reset = 1;
        test_reset();
        prefill();
        test_store_load();
        test_strobe();
        test_load_before_store();
        test_full_stall();
        test_lat1_stream();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
